alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width, power of two, 8..64.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1: operation request present.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operation.
REQ-006 SHALL have port alu_ctrl, input, 4: operation code from the ALU control stage.
REQ-007 SHALL have ports src_a and src_b, input, WIDTH: operands.
REQ-008 SHALL have port out_valid, output, 1: result available.
REQ-009 SHALL have port out_ready, input, 1: consumer takes result.
REQ-010 SHALL have port result, output, WIDTH: registered result.
REQ-011 SHALL have port zero, output, 1: high when result == 0.
REQ-012 SHALL have port busy, output, 1: high whenever state != IDLE.

Function
REQ-013 SHALL decode alu_ctrl as follows: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA; codes 1010-1111 SHALL execute as ADD.
REQ-014 SHALL perform ADD and SUB modulo 2^WIDTH with no carry or overflow output; SLT and SLTU SHALL produce 1 or 0 zero-extended to WIDTH.
REQ-015 SHALL take the shift amount from src_b[log2(WIDTH)-1:0] and ignore the upper bits; SRA SHALL fill with src_a[WIDTH-1].
REQ-016 SHALL implement a state machine with states IDLE, SHIFT, and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept an operation on a cycle where in_valid and in_ready are both 1, capturing alu_ctrl, src_a, and src_b; later input changes SHALL be ignored until the next accept.
REQ-018 SHALL, for a non-shift op or a shift with amount 0, load result and go IDLE->DONE on the accept edge: latency 1, with out_valid high in the next cycle.
REQ-019 SHALL, for a shift with amount N>0 (iterative mode), go IDLE->SHIFT, shift 1 bit per cycle using a down-counter loaded with N, and go SHIFT->DONE when the counter reaches 0: out_valid asserted N+1 cycles after accept.
REQ-020 SHALL, in DONE, hold out_valid=1 and keep result and zero stable until out_ready=1; on that edge it SHALL go DONE->IDLE with out_valid=0 the next cycle.
REQ-021 SHALL ignore in_valid in SHIFT and DONE without queuing it: no back-to-back acceptance, minimum 2 cycles per operation.
REQ-022 SHALL drive zero combinationally from the registered result; zero is meaningful only while out_valid=1.
REQ-023 SHALL ignore out_ready when out_valid=0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE with result=0, out_valid=0, busy=0, and shift counter=0; in_ready SHALL be 1 in the following cycle.
REQ-025 SHALL give rst priority over every handshake; reset in SHIFT or DONE SHALL discard the operation with no out_valid pulse.
REQ-026 SHALL not accept an operation while rst=1, even if in_valid=1.

Configuration
REQ-027 SHALL use macro ALU_FAST_SHIFT_EN; when it is defined, SLL/SRL/SRA SHALL complete in one cycle per REQ-018, the SHIFT state and counter SHALL be absent, and busy SHALL equal out_valid.
REQ-028 SHALL, when ALU_FAST_SHIFT_EN is undefined, use iterative shifts per REQ-019; results SHALL be bit-identical in both modes.

Verification
REQ-029 SHALL cover: SUB, src_a=5, src_b=7, out_ready=1 -> result=0xFFFFFFFE, zero=0, out_valid for exactly 1 cycle starting 1 cycle after accept.
REQ-030 SHALL cover: SRA, src_a=0x80000000, src_b=0x24 (amount 4), iterative -> result=0xF8000000, out_valid 5 cycles after accept, in_ready=0 throughout; with ALU_FAST_SHIFT_EN -> same result after 1 cycle.
REQ-031 SHALL cover: SLT, src_a=0xFFFFFFFF, src_b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-032 SHALL cover: ADD, src_a=3, src_b=0xFFFFFFFD, out_ready=0 for 4 cycles -> result=0, zero=1, both held stable with out_valid=1 until out_ready rises; a second in_valid during the hold is not accepted.
REQ-033 SHALL cover: SLL, src_a=1, src_b=31, rst pulsed 10 cycles after accept -> no out_valid, result=0, in_ready=1 in the cycle after reset deasserts.
REQ-034 SHALL cover: alu_ctrl=1111, src_a=2, src_b=3 -> result=5.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: single-operation ALU with valid/ready handshake and registered result.
// Optional macro ALU_FAST_SHIFT_EN: shifts finish in one cycle instead of one bit per cycle.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] alu_y;
    logic [SHW-1:0]   shamt;

    assign shamt = src_b[SHW-1:0];

    // Single-cycle result; in iterative mode shifts pass src_a through as the
    // starting value of the shift register (also the correct amount-0 result).
    always_comb begin
        alu_y = src_a + src_b;
        case (alu_ctrl)
            OP_ADD:  alu_y = src_a + src_b;
            OP_SUB:  alu_y = src_a - src_b;
            OP_AND:  alu_y = src_a & src_b;
            OP_OR:   alu_y = src_a | src_b;
            OP_XOR:  alu_y = src_a ^ src_b;
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  alu_y = src_a << shamt;
            OP_SRL:  alu_y = src_a >> shamt;
            OP_SRA:  alu_y = $signed(src_a) >>> shamt;
`else
            OP_SLL:  alu_y = src_a;
            OP_SRL:  alu_y = src_a;
            OP_SRA:  alu_y = src_a;
`endif
            default: alu_y = src_a + src_b;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    result_d = alu_y;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end
`else
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [3:0]     op_q, op_d;
    logic           is_shift;

    assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    result_d = alu_y;
                    if (is_shift && (shamt != '0)) begin
                        state_d = SHIFT;
                        cnt_d   = shamt;
                        op_d    = alu_ctrl;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                // result_q doubles as the shift register while iterating
                case (op_q)
                    OP_SLL:  result_d = {result_q[WIDTH-2:0], 1'b0};
                    OP_SRL:  result_d = {1'b0, result_q[WIDTH-1:1]};
                    default: result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                endcase
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign state_dbg = state_q;

endmodule
